// File: rtl/mem_access_ctrl.sv
// Data-memory stage sequencer: latches one request, drives a single issue/busy/done
// transaction to multi-cycle memory, stalls the pipeline meanwhile, handles HALT and faults.
module mem_access_ctrl #(
  parameter int unsigned DataW   = 16,
  parameter int unsigned AddrW   = 16,
  parameter int unsigned Timeout = 31
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_en_i,
  input  logic             req_wr_i,
  input  logic             req_dump_i,
  input  logic [AddrW-1:0] req_addr_i,
  input  logic [DataW-1:0] req_wdata_i,
  output logic             stall_o,
  output logic [DataW-1:0] rdata_o,
  output logic             rdata_valid_o,
  output logic             halted_o,
  output logic             err_o,
  output logic             mem_en_o,
  output logic             mem_wr_o,
  output logic             mem_dump_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic             mem_busy_i,
  input  logic             mem_done_i,
  input  logic [DataW-1:0] mem_rdata_i,
  input  logic             mem_err_i
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDone,
    StHalt,
    StErr
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(Timeout);

  state_e             state_q;
  logic               wr_q;
  logic               dump_q;
  logic [AddrW-1:0]   addr_q;
  logic [DataW-1:0]   wdata_q;
  logic [DataW-1:0]   rdata_q;
  logic               rdata_valid_q;
  logic               halted_q;
  logic               err_q;
  logic               mem_en_q;
  logic               mem_wr_q;
  logic               mem_dump_q;
  logic [7:0]         wait_cnt_q;
  logic [7:0]         wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q + 8'd1;
  end

  // Strobes are registered: they are set on the IDLE->ISSUE edge and dropped when the
  // memory accepts, so they stay stable for every busy cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wr_q          <= 1'b0;
      dump_q        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_dump_q    <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_en_i) begin
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            dump_q     <= req_dump_i;
            wr_q       <= req_wr_i & ~req_dump_i;
            mem_en_q   <= ~req_dump_i;
            mem_dump_q <= req_dump_i;
            mem_wr_q   <= req_wr_i & ~req_dump_i;
            wait_cnt_q <= '0;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (!mem_busy_i) begin
            mem_en_q   <= 1'b0;
            mem_dump_q <= 1'b0;
            mem_wr_q   <= 1'b0;
            if (dump_q) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              state_q  <= StWait;
            end
          end
        end
        StWait: begin
          wait_cnt_q <= wait_cnt_d;
          if (mem_err_i) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end else if (mem_done_i) begin
            if (!wr_q) begin
              rdata_q       <= mem_rdata_i;
              rdata_valid_q <= 1'b1;
            end
            state_q <= StDone;
          end else if (wait_cnt_d >= TimeoutCnt) begin
            err_q   <= 1'b1;
            state_q <= StErr;
          end
        end
        StDone: begin
          // Pipeline advances now; any req_en seen here belongs to the retiring instruction.
          wait_cnt_q <= '0;
          state_q    <= StIdle;
        end
        StHalt: state_q <= StHalt;
        StErr:  state_q <= StErr;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StIdle:  stall_o = req_en_i;
      StDone:  stall_o = 1'b0;
      default: stall_o = 1'b1;
    endcase
  end

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign halted_o      = halted_q;
  assign err_o         = err_q;
  assign mem_en_o      = mem_en_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_dump_o    = mem_dump_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected memory requests and load
// results into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic        req_wr = 1'b0;
  logic        req_dump = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        halted;
  logic        err;
  logic        mem_en;
  logic        mem_wr;
  logic        mem_dump;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_busy = 1'b0;
  logic        mem_done = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_err = 1'b0;

  typedef struct {
    logic        en;
    logic        dump;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cycles;
  } req_t;

  req_t        exp_req[$];
  logic [15:0] exp_rd[$];
  int          n_pass = 0;
  int          n_total = 0;

  mem_access_ctrl #(
    .DataW  (16),
    .AddrW  (16),
    .Timeout(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_en_i     (req_en),
    .req_wr_i     (req_wr),
    .req_dump_i   (req_dump),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .stall_o      (stall),
    .rdata_o      (rdata),
    .rdata_valid_o(rdata_valid),
    .halted_o     (halted),
    .err_o        (err),
    .mem_en_o     (mem_en),
    .mem_wr_o     (mem_wr),
    .mem_dump_o   (mem_dump),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_busy_i   (mem_busy),
    .mem_done_i   (mem_done),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_rvalid"}, rdata_valid, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_strobes"}, {mem_en, mem_wr, mem_dump}, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  // Starts and ends at posedge+1 with the DUT in IDLE.
  task automatic run_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rd, input int busy_cyc, input int wait_cyc);
    req_t r;
    r = '{en: 1'b1, dump: 1'b0, wr: wr, addr: addr, wdata: wdata, cycles: busy_cyc + 1};
    exp_req.push_back(r);
    if (!wr) exp_rd.push_back(rd);
    req_en = 1'b1; req_wr = wr; req_dump = 1'b0; req_addr = addr; req_wdata = wdata;
    at_neg(); check("idle_stall", stall, 1);
    tick();
    req_en = 1'b0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
    // mem_done during busy ISSUE cycles must be ignored
    mem_busy = (busy_cyc > 0); mem_done = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      at_neg(); check("busy_stall", stall, 1);
      tick();
    end
    mem_busy = 1'b0; mem_done = 1'b0;
    at_neg(); check("issue_stall", stall, 1);
    tick();
    for (int i = 0; i < wait_cyc; i++) begin
      at_neg(); check("wait_stall", stall, 1);
      tick();
    end
    mem_done = 1'b1; mem_rdata = rd;
    at_neg(); check("wait_stall", stall, 1);
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    at_neg();
    check("done_stall", stall, 0);
    check("done_rvalid", rdata_valid, {31'd0, ~wr});
    tick();
  endtask

  initial begin : monitor
    int   strobe_cnt;
    req_t r;
    strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        strobe_cnt = 0;
      end else begin
        if (mem_en || mem_dump) begin
          if (exp_req.size() == 0) begin
            check("unexpected_strobe", {mem_en, mem_dump}, 0);
          end else begin
            check("req_en", mem_en, exp_req[0].en);
            check("req_dump", mem_dump, exp_req[0].dump);
            check("req_wr", mem_wr, exp_req[0].wr);
            check("req_addr", mem_addr, exp_req[0].addr);
            check("req_wdata", mem_wdata, exp_req[0].wdata);
            strobe_cnt++;
          end
        end else if (strobe_cnt > 0) begin
          r = exp_req.pop_front();
          check("strobe_len", strobe_cnt, r.cycles);
          strobe_cnt = 0;
        end
        if (rdata_valid) begin
          if (exp_rd.size() == 0) check("unexpected_rvalid", rdata_valid, 0);
          else check("rdata", rdata, exp_rd.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    req_t r;
    at_neg();
    chk_zero("reset");
    tick();
    rst = 1'b0;

    // Load with no busy; mem_done one cycle after ISSUE
    run_access(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 0);
    at_neg();
    check("rdata_hold", rdata, 16'hBEEF);
    check("idle_rvalid", rdata_valid, 0);
    tick();

    // Store held off by busy for 3 cycles, completing after 3 WAIT cycles
    run_access(1'b1, 16'h0010, 16'h1234, 16'hAAAA, 3, 2);
    at_neg();
    check("store_keeps_rdata", rdata, 16'hBEEF);
    tick();

    // Back-to-back loads with req_en held high across DONE
    r = '{en: 1'b1, dump: 1'b0, wr: 1'b0, addr: 16'h0100, wdata: 16'h0000, cycles: 1};
    exp_req.push_back(r);
    exp_rd.push_back(16'h1111);
    req_en = 1'b1; req_wr = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0000;
    tick();                                   // c1 ISSUE
    tick();                                   // c2 WAIT
    mem_done = 1'b1; mem_rdata = 16'h1111;
    tick();                                   // c3 DONE
    mem_done = 1'b0; mem_rdata = '0;
    at_neg(); check("b2b_done_stall", stall, 0);
    tick();                                   // c4 IDLE, pipeline advanced
    req_addr = 16'h0102;
    r = '{en: 1'b1, dump: 1'b0, wr: 1'b0, addr: 16'h0102, wdata: 16'h0000, cycles: 1};
    exp_req.push_back(r);
    exp_rd.push_back(16'h2222);
    at_neg();
    check("b2b_idle_en", mem_en, 0);
    check("b2b_idle_stall", stall, 1);
    tick();                                   // c5 ISSUE
    req_en = 1'b0;
    at_neg(); check("b2b_second_en", mem_en, 1);
    tick();                                   // c6 WAIT
    mem_done = 1'b1; mem_rdata = 16'h2222;
    tick();                                   // c7 DONE
    mem_done = 1'b0; mem_rdata = '0;
    at_neg(); check("b2b_done2_stall", stall, 0);
    tick();

    // Reset while in WAIT; a late mem_done must not produce rdata_valid
    r = '{en: 1'b1, dump: 1'b0, wr: 1'b0, addr: 16'h0300, wdata: 16'h0000, cycles: 1};
    exp_req.push_back(r);
    req_en = 1'b1; req_addr = 16'h0300;
    tick();                                   // ISSUE
    req_en = 1'b0;
    tick();                                   // WAIT
    tick();                                   // WAIT
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    tick();
    rst = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    at_neg(); check("late_done_rvalid", rdata_valid, 0);
    tick();
    mem_done = 1'b0; mem_rdata = '0;
    at_neg();
    check("late_done_rvalid2", rdata_valid, 0);
    check("late_done_stall", stall, 0);
    tick();

    // Timeout after 4 WAIT cycles without mem_done
    r = '{en: 1'b1, dump: 1'b0, wr: 1'b0, addr: 16'h0200, wdata: 16'h0000, cycles: 1};
    exp_req.push_back(r);
    req_en = 1'b1; req_addr = 16'h0200;
    tick();                                   // ISSUE
    req_en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("to_wait_err", err, 0);
      check("to_wait_stall", stall, 1);
      tick();
    end
    at_neg();
    check("to_err", err, 1);
    check("to_err_stall", stall, 1);
    tick();
    req_en = 1'b1; req_addr = 16'h0204; mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("err_sticky", err, 1);
      check("err_stall", stall, 1);
      check("err_no_en", mem_en, 0);
      tick();
    end
    req_en = 1'b0; mem_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    at_neg(); check("err_cleared", err, 0);
    tick();

    // Dump overrides the write flag
    r = '{en: 1'b0, dump: 1'b1, wr: 1'b0, addr: 16'h0ABC, wdata: 16'h5555, cycles: 1};
    exp_req.push_back(r);
    req_en = 1'b1; req_dump = 1'b1; req_wr = 1'b1; req_addr = 16'h0ABC; req_wdata = 16'h5555;
    tick();                                   // ISSUE
    req_en = 1'b0; req_dump = 1'b0; req_wr = 1'b0;
    at_neg(); check("dump_issue_halted", halted, 0);
    tick();
    req_en = 1'b1; req_addr = 16'h0AC0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("halted", halted, 1);
      check("halt_stall", stall, 1);
      check("halt_no_en", mem_en, 0);
      tick();
    end
    req_en = 1'b0;

    check("req_queue_empty", exp_req.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
